// File: rtl/coproc_pkg.sv
// rtl/coproc_pkg.sv - shared opcodes, state encoding and instruction field layout
package coproc_pkg;

   localparam logic [2:0] OP_LOAD   = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b001;
   localparam logic [2:0] OP_SUB    = 3'b010;
   localparam logic [2:0] OP_MUL    = 3'b011;
   localparam logic [2:0] OP_TRANSP = 3'b100;
   localparam logic [2:0] OP_SCALAR = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_LOAD,
      ST_EXEC,
      ST_WB,
      ST_DONE
   } state_t;

   // Instruction word layout (low 16 bits of the fetched memory word)
   localparam int INSTR_W   = 16;
   localparam int OPC_LSB   = 0;
   localparam int OPC_W     = 3;
   localparam int SIZE_LSB  = 3;
   localparam int SIZE_W    = 3;
   localparam int BANK_BIT  = 6;
   localparam int LADDR_LSB = 7;
   localparam int LADDR_W   = 8;

   localparam int DEF_INSTR_ADDR = 0;
   localparam int DEF_RES_ADDR   = 3;

endpackage

// File: rtl/matrix_coproc_ctrl_if.sv
// rtl/matrix_coproc_ctrl_if.sv - memory and matrix ALU handshake bundle
interface matrix_coproc_ctrl_if #(
   parameter int DATA_W = 200,
   parameter int ADDR_W = 8,
   parameter int ELEM_W = 8
);
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              mem_wready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [2:0]        alu_opcode;
   logic [2:0]        alu_size;
   logic [ELEM_W-1:0] alu_scalar;
   logic              alu_start;
   logic [DATA_W-1:0] alu_result;
   logic              alu_done;

   // Controller side
   modport master (
      input  mem_rdata, mem_rvalid, mem_wready, alu_result, alu_done,
      output mem_addr, mem_re, mem_we, mem_wdata,
             alu_a, alu_b, alu_opcode, alu_size, alu_scalar, alu_start
   );

   // Memory / ALU side
   modport slave (
      output mem_rdata, mem_rvalid, mem_wready, alu_result, alu_done,
      input  mem_addr, mem_re, mem_we, mem_wdata,
             alu_a, alu_b, alu_opcode, alu_size, alu_scalar, alu_start
   );
endinterface

// File: rtl/coproc_instr_decode.sv
// rtl/coproc_instr_decode.sv - instruction field extraction and size legality check
module coproc_instr_decode
   import coproc_pkg::*;
#(
   parameter int MAX_N = 5
) (
   input  logic [INSTR_W-1:0] instr,
   output logic [OPC_W-1:0]   opcode,
   output logic [SIZE_W-1:0]  size,
   output logic               bank,
   output logic [LADDR_W-1:0] load_addr,
   output logic               legal
);

   // The top bit is reserved and deliberately ignored.
   logic unused_reserved;
   assign unused_reserved = instr[INSTR_W-1];

   // Split fields; loads never use the size so only ALU ops are range checked
   always_comb begin
      opcode    = instr[OPC_LSB +: OPC_W];
      size      = instr[SIZE_LSB +: SIZE_W];
      bank      = instr[BANK_BIT];
      load_addr = instr[LADDR_LSB +: LADDR_W];
      legal     = (opcode == OP_LOAD) ||
                  ((size >= 3'd2) && (int'(size) <= MAX_N));
   end

endmodule

// File: rtl/matrix_coproc_ctrl.sv
// rtl/matrix_coproc_ctrl.sv - matrix coprocessor instruction sequencer
module matrix_coproc_ctrl
   import coproc_pkg::*;
#(
   parameter int ELEM_W     = 8,
   parameter int MAX_N      = 5,
   parameter int DATA_W     = ELEM_W * MAX_N * MAX_N,
   parameter int ADDR_W     = 8,
   parameter int INSTR_ADDR = DEF_INSTR_ADDR,
   parameter int RES_ADDR   = DEF_RES_ADDR,
   parameter int TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   matrix_coproc_ctrl_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t state_q, state_d;

   logic [INSTR_W-1:0] instr_q;
   logic [DATA_W-1:0]  a_q, b_q, res_q;
   logic [OPC_W-1:0]   opcode_q;
   logic [SIZE_W-1:0]  size_q;
   logic               bank_q;
   logic [ELEM_W-1:0]  scalar_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;

   logic [OPC_W-1:0]   dec_opcode;
   logic [SIZE_W-1:0]  dec_size;
   logic               dec_bank;
   logic [LADDR_W-1:0] dec_load_addr;
   logic               dec_legal;

   // The start cycle (cnt_q == 0) ignores alu_done so a stale pulse cannot complete the op
   logic exec_first, alu_ok;
   assign exec_first = (cnt_q == '0);
   assign alu_ok     = !exec_first && bus.alu_done;

   coproc_instr_decode #(.MAX_N(MAX_N)) u_decode (
      .instr     (instr_q),
      .opcode    (dec_opcode),
      .size      (dec_size),
      .bank      (dec_bank),
      .load_addr (dec_load_addr),
      .legal     (dec_legal)
   );

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         instr_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         opcode_q <= '0;
         size_q   <= '0;
         bank_q   <= 1'b0;
         scalar_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) err_q <= 1'b0;
            end
            ST_FETCH: begin
               if (bus.mem_rvalid) instr_q <= bus.mem_rdata[INSTR_W-1:0];
            end
            ST_DECODE: begin
               opcode_q <= dec_opcode;
               size_q   <= dec_size;
               bank_q   <= dec_bank;
               scalar_q <= b_q[ELEM_W-1:0];
               cnt_q    <= '0;
               if (!dec_legal) err_q <= 1'b1;
            end
            ST_LOAD: begin
               if (bus.mem_rvalid) begin
                  if (bank_q) b_q <= bus.mem_rdata;
                  else        a_q <= bus.mem_rdata;
               end
            end
            ST_EXEC: begin
               cnt_q <= cnt_q + 1'b1;
               if (alu_ok)                  res_q <= bus.alu_result;
               else if (cnt_q == CNT_LAST)  err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next state and handshake outputs; every output idles at zero
   always_comb begin
      state_d       = state_q;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.alu_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = ADDR_W'(INSTR_ADDR);
            if (bus.mem_rvalid) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (!dec_legal)                    state_d = ST_DONE;
            else if (dec_opcode == OP_LOAD)    state_d = ST_LOAD;
            else                               state_d = ST_EXEC;
         end
         ST_LOAD: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = ADDR_W'(dec_load_addr);
            if (bus.mem_rvalid) state_d = ST_DONE;
         end
         ST_EXEC: begin
            bus.alu_start = exec_first;
            if (alu_ok)                  state_d = ST_WB;
            else if (cnt_q == CNT_LAST)  state_d = ST_DONE;
         end
         ST_WB: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = ADDR_W'(RES_ADDR);
            bus.mem_wdata = res_q;
            if (bus.mem_wready) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_opcode = opcode_q;
   assign bus.alu_size   = size_q;
   assign bus.alu_scalar = scalar_q;

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign err  = err_q;

endmodule

// File: tb/tb_matrix_coproc_ctrl.sv
// tb/tb_matrix_coproc_ctrl.sv - table-driven checks for the matrix coprocessor controller
module tb_matrix_coproc_ctrl;

   localparam int DW = 200;

   localparam logic [DW-1:0] A1 = {25{8'h01}};
   localparam logic [DW-1:0] B1 = {25{8'h02}};
   localparam logic [DW-1:0] B2 = {{24{8'h02}}, 8'h07};
   localparam logic [DW-1:0] R1 = {25{8'hA5}};
   localparam logic [DW-1:0] R2 = {25{8'h3C}};
   localparam logic [DW-1:0] R3 = {25{8'h5A}};

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic busy, done, err;

   matrix_coproc_ctrl_if #(.DATA_W(DW), .ADDR_W(8), .ELEM_W(8)) bus ();

   matrix_coproc_ctrl #(
      .ELEM_W(8), .MAX_N(5), .ADDR_W(8),
      .INSTR_ADDR(0), .RES_ADDR(3), .TIMEOUT(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]   word;
      logic [DW-1:0] data;
      int            delay;      // ALU cycles after alu_start; 0 = never answers
      int            wstall;     // write cycles refused before mem_wready
      int            restart_at; // cycle index at which start is re-pulsed; 0 = none
      logic [DW-1:0] res;
      int            lat;
      int            starts;
      int            we_cycles;
      logic          err;
      int            ld_addr;    // -1 = not checked
      logic          chk_ab;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          chk_scalar;
      logic [7:0]    scalar;
   } vec_t;

   vec_t vecs [12];

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rd_data [2];
   int            rd_idx, alu_delay, alu_cnt, wstall;
   logic          prev_rd;
   logic [DW-1:0] alu_res_val;

   int            obs_lat, obs_starts, obs_we, obs_overlap, obs_unstable, obs_ld_addr;
   logic          obs_err, obs_err_first, obs_done;
   logic [7:0]    obs_wa;
   logic [DW-1:0] obs_wd;
   logic [7:0]    obs_scalar;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory and ALU responder, called once per cycle at the falling edge
   task automatic service();
      if (prev_rd && rd_idx < 1) rd_idx++;
      prev_rd = bus.mem_re;
      bus.mem_rvalid = bus.mem_re;
      bus.mem_rdata  = bus.mem_re ? rd_data[rd_idx] : '0;
      if (bus.mem_we) begin
         if (wstall > 0) begin
            wstall--;
            bus.mem_wready = 1'b0;
         end else begin
            bus.mem_wready = 1'b1;
         end
      end else begin
         bus.mem_wready = 1'b0;
      end
      if (bus.alu_start) begin
         alu_cnt = alu_delay;
         bus.alu_done = 1'b0;
      end else if (alu_cnt > 0) begin
         alu_cnt--;
         bus.alu_done = (alu_cnt == 0);
      end else begin
         bus.alu_done = 1'b0;
      end
      bus.alu_result = alu_res_val;
   endtask

   task automatic run_vec(input vec_t v);
      rd_data[0]  = {{(DW-16){1'b0}}, v.word};
      rd_data[1]  = v.data;
      rd_idx      = 0;
      prev_rd     = 1'b0;
      alu_delay   = v.delay;
      alu_cnt     = 0;
      alu_res_val = v.res;
      wstall      = v.wstall;
      obs_lat = 0; obs_starts = 0; obs_we = 0; obs_overlap = 0; obs_unstable = 0;
      obs_ld_addr = -1; obs_err = 1'b0; obs_err_first = 1'b1; obs_done = 1'b0;
      obs_wa = '0; obs_wd = '0; obs_scalar = '0;
      start = 1'b1;
      service();
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         obs_lat = c;
         if (c == 1) obs_err_first = err;
         if (bus.alu_start) begin
            obs_starts++;
            obs_scalar = bus.alu_scalar;
         end
         if (bus.mem_re) obs_ld_addr = int'(bus.mem_addr);
         if (bus.mem_we) begin
            if (obs_we > 0 && (bus.mem_addr !== obs_wa || bus.mem_wdata !== obs_wd))
               obs_unstable++;
            obs_wa = bus.mem_addr;
            obs_wd = bus.mem_wdata;
            obs_we++;
         end
         if (bus.mem_re && bus.mem_we) obs_overlap++;
         if (done) begin
            obs_err  = err;
            obs_done = 1'b1;
            start    = 1'b0;
            service();
            break;
         end
         start = (c == v.restart_at);
         service();
         @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
      service();
   endtask

   initial begin
      int seen;
      vecs[0]  = '{16'h0000, A1, 0, 0, 0, '0,  4, 0, 0, 1'b0,  0, 1'b1, A1, '0, 1'b0, 8'h00};
      vecs[1]  = '{16'h0140, B1, 0, 0, 0, '0,  4, 0, 0, 1'b0,  2, 1'b1, A1, B1, 1'b0, 8'h00};
      vecs[2]  = '{16'h0029, '0, 3, 0, 0, R1,  8, 1, 1, 1'b0, -1, 1'b1, A1, B1, 1'b0, 8'h00};
      vecs[3]  = '{16'h0012, '0, 1, 0, 0, R2,  6, 1, 1, 1'b0, -1, 1'b0, '0, '0, 1'b0, 8'h00};
      vecs[4]  = '{16'h0039, '0, 1, 0, 0, R1,  3, 0, 0, 1'b1, -1, 1'b0, '0, '0, 1'b0, 8'h00};
      vecs[5]  = '{16'h0009, '0, 1, 0, 0, R1,  3, 0, 0, 1'b1, -1, 1'b0, '0, '0, 1'b0, 8'h00};
      vecs[6]  = '{16'h0031, '0, 1, 0, 0, R1,  3, 0, 0, 1'b1, -1, 1'b0, '0, '0, 1'b0, 8'h00};
      vecs[7]  = '{16'h0140, B2, 0, 0, 0, '0,  4, 0, 0, 1'b0,  2, 1'b1, A1, B2, 1'b0, 8'h00};
      vecs[8]  = '{16'h001D, '0, 1, 0, 0, R3,  6, 1, 1, 1'b0, -1, 1'b0, '0, '0, 1'b1, 8'h07};
      vecs[9]  = '{16'h0023, '0, 0, 0, 0, R1,  7, 1, 0, 1'b1, -1, 1'b0, '0, '0, 1'b0, 8'h00};
      vecs[10] = '{16'h0029, '0, 1, 5, 0, R2, 11, 1, 6, 1'b0, -1, 1'b0, '0, '0, 1'b0, 8'h00};
      vecs[11] = '{16'h0029, '0, 3, 0, 4, R3,  8, 1, 1, 1'b0, -1, 1'b1, A1, B2, 1'b0, 8'h00};

      reset = 1'b1;
      start = 1'b0;
      bus.mem_rdata = '0; bus.mem_rvalid = 1'b0; bus.mem_wready = 1'b0;
      bus.alu_result = '0; bus.alu_done = 1'b0;
      rd_data[0] = '0; rd_data[1] = '0; rd_idx = 0; prev_rd = 1'b0;
      alu_delay = 0; alu_cnt = 0; wstall = 0; alu_res_val = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset ctl", DW'({busy, done, err, bus.mem_re, bus.mem_we, bus.alu_start}), '0);
      check("reset regs", DW'({bus.mem_addr, bus.alu_opcode, bus.alu_size, bus.alu_scalar}), '0);
      check("reset alu_a", bus.alu_a, '0);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i]);
         check($sformatf("row%0d done_seen", i), DW'(obs_done), DW'(1'b1));
         check($sformatf("row%0d latency", i), DW'(obs_lat), DW'(vecs[i].lat));
         check($sformatf("row%0d alu_starts", i), DW'(obs_starts), DW'(vecs[i].starts));
         check($sformatf("row%0d we_cycles", i), DW'(obs_we), DW'(vecs[i].we_cycles));
         check($sformatf("row%0d err", i), DW'(obs_err), DW'(vecs[i].err));
         check($sformatf("row%0d err_cleared", i), DW'(obs_err_first), '0);
         check($sformatf("row%0d re_we_overlap", i), DW'(obs_overlap), '0);
         check($sformatf("row%0d idle_after", i), DW'(busy), '0);
         if (vecs[i].we_cycles > 0) begin
            check($sformatf("row%0d wr_addr", i), DW'(obs_wa), DW'(8'd3));
            check($sformatf("row%0d wr_data", i), obs_wd, vecs[i].res);
            check($sformatf("row%0d wr_stable", i), DW'(obs_unstable), '0);
         end
         if (vecs[i].ld_addr >= 0)
            check($sformatf("row%0d ld_addr", i), DW'(obs_ld_addr), DW'(vecs[i].ld_addr));
         if (vecs[i].chk_ab) begin
            check($sformatf("row%0d alu_a", i), bus.alu_a, vecs[i].a);
            check($sformatf("row%0d alu_b", i), bus.alu_b, vecs[i].b);
         end
         if (vecs[i].chk_scalar)
            check($sformatf("row%0d scalar", i), DW'(obs_scalar), DW'(vecs[i].scalar));
      end

      // Reset while WB is stalled on mem_wready
      rd_data[0] = {{(DW-16){1'b0}}, 16'h0029};
      rd_idx = 0; prev_rd = 1'b0; alu_delay = 1; alu_cnt = 0;
      alu_res_val = R1; wstall = 1000;
      start = 1'b1;
      service();
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.mem_we) begin
            seen = 1;
            break;
         end
         service();
         @(negedge clk);
      end
      check("wb_reached", DW'(seen), DW'(1));
      service();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("wbrst ctl", DW'({busy, done, err, bus.mem_re, bus.mem_we, bus.alu_start}), '0);
      check("wbrst regs", DW'({bus.mem_addr, bus.alu_opcode, bus.alu_size, bus.alu_scalar}), '0);
      check("wbrst wdata", bus.mem_wdata, '0);
      check("wbrst alu_a", bus.alu_a, '0);
      check("wbrst alu_b", bus.alu_b, '0);
      wstall = 0;
      alu_cnt = 0;
      service();
      @(negedge clk);
      check("wbrst stays idle", DW'(busy), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
